// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, FSM encoding, reset PC.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          OPCODE_W         = 6;

    localparam logic [OPCODE_W-1:0] OP_J   = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Branch displacement is a signed word offset; turn it into a byte offset.
    function automatic logic [31:0] branch_byte_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of instruction-memory, decode-stage and control-decoder signals around the fetch unit.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                imem_req;
    logic [31:0]         imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic [31:0]         instr;
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [31:0]         pc;
    logic [31:0]         pc_plus4;
    logic                branch;
    logic                mux_pc_branch;
    logic                mux_branch_jump;
    logic                zero;
    logic [31:0]         retired;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, opcode, pc, pc_plus4, retired,
        input  imem_ack, imem_rdata, instr_ready, branch, mux_pc_branch, mux_branch_jump, zero
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, opcode, pc, pc_plus4, retired,
        output imem_ack, imem_rdata, instr_ready, branch, mux_pc_branch, mux_branch_jump, zero
    );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: jump, taken BEQ/BNE branch, or fall-through.
module mips_next_pc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    input  logic        branch_i,
    input  logic        mux_pc_branch_i,
    input  logic        mux_branch_jump_i,
    input  logic        zero_i,
    output logic [31:0] next_pc_o
);

    logic [OPCODE_W-1:0] opcode;
    logic                condMet;
    logic                branchTaken;
    logic [31:0]         jumpTarget;
    logic [31:0]         branchTarget;

    assign opcode       = instr_i[31:26];
    assign jumpTarget   = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
    assign branchTarget = pc_plus4_i + branch_byte_offset(instr_i[15:0]);

    // BEQ wants the ALU to report equality, BNE wants inequality; other opcodes never branch.
    always_comb begin
        condMet = 1'b0;
        if (opcode == OP_BEQ) begin
            condMet = zero_i;
        end else if (opcode == OP_BNE) begin
            condMet = ~zero_i;
        end
    end

    assign branchTaken = branch_i & mux_pc_branch_i & condMet;

    // Jump outranks a taken branch, which outranks sequential flow.
    always_comb begin
        next_pc_o = pc_plus4_i;
        if (!mux_branch_jump_i) begin
            next_pc_o = jumpTarget;
        end else if (branchTaken) begin
            next_pc_o = branchTarget;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests a word, holds it for decode, advances PC on retirement.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic          clk,
    input  logic          nrst,
    fetch_unit_if.master  fu_if
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] retired_q;
    logic [31:0] retired_d;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        fetchAccept;
    logic        retire;

    assign pc_plus4 = pc_q + 32'd4;

    mips_next_pc u_next_pc (
        .pc_plus4_i        (pc_plus4),
        .instr_i           (instr_q),
        .branch_i          (fu_if.branch),
        .mux_pc_branch_i   (fu_if.mux_pc_branch),
        .mux_branch_jump_i (fu_if.mux_branch_jump),
        .zero_i            (fu_if.zero),
        .next_pc_o         (next_pc)
    );

    // State register; reset parks the FSM in IDLE and drops any outstanding work.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE always starts fetching, FETCH waits for ack, HOLD waits for retirement.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (fu_if.imem_ack)    state_d = ST_HOLD;
            ST_HOLD:  if (fu_if.instr_ready) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore outputs plus the two qualified events that move the datapath.
    always_comb begin
        fu_if.imem_req    = (state_q == ST_FETCH);
        fu_if.instr_valid = (state_q == ST_HOLD);
        fetchAccept       = (state_q == ST_FETCH) && fu_if.imem_ack;
        retire            = (state_q == ST_HOLD) && fu_if.instr_ready;
    end

    // Datapath next values; acks outside FETCH and controls outside retirement are ignored.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        if (fetchAccept) begin
            instr_d = fu_if.imem_rdata;
        end
        if (retire) begin
            pc_d      = next_pc;
            retired_d = retired_q + 32'd1;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign fu_if.imem_addr = pc_q;
    assign fu_if.instr     = instr_q;
    assign fu_if.opcode    = instr_q[31:26];
    assign fu_if.pc        = pc_q;
    assign fu_if.pc_plus4  = pc_plus4;
    assign fu_if.retired   = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard testbench for fetch_unit: directed scenarios followed by randomized traffic.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] retiredBefore;
    } txn_t;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic nrst;

    fetch_unit_if fif();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .fu_if (fif)
    );

    always #5 clk = ~clk;

    int          checkCount = 0;
    int          errorCount = 0;
    txn_t        expQ[$];
    bit          monEn = 1'b0;
    logic [31:0] mPc;
    logic [31:0] mRetired;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFail(input string name);
        checkCount++;
        errorCount++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Reference next-PC from the instruction-set rules, using plain integer arithmetic.
    function automatic logic [31:0] modelNextPc(input logic [31:0] pc, input logic [31:0] instr,
                                                input bit br, input bit mpb, input bit mbj, input bit z);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        if (!mbj) return {pc4[31:28], instr[25:0], 2'b00};
        off = int'($signed(instr[15:0]));
        if (br && mpb && ((instr[31:26] == OP_BEQ && z) || (instr[31:26] == OP_BNE && !z)))
            return pc4 + 32'(off * 4);
        return pc4;
    endfunction

    task automatic randomControls();
        fif.branch          = 1'($urandom);
        fif.mux_pc_branch   = 1'($urandom);
        fif.mux_branch_jump = 1'($urandom);
        fif.zero            = 1'($urandom);
    endtask

    task automatic waitReq(output bit ok);
        int n = 0;
        while (!fif.imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = fif.imem_req;
        if (!ok) reportFail("timeout_imem_req");
    endtask

    task automatic waitValid(output bit ok);
        int n = 0;
        while (!fif.instr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = fif.instr_valid;
        if (!ok) reportFail("timeout_instr_valid");
    endtask

    task automatic fetchPhase(input logic [31:0] instr, input int ackDelay);
        bit ok;
        waitReq(ok);
        if (!ok) return;
        repeat (ackDelay) begin
            fif.imem_ack   = 1'b0;
            fif.imem_rdata = $urandom;
            randomControls();
            @(posedge clk); #1;
        end
        fif.imem_ack   = 1'b1;
        fif.imem_rdata = instr;
        @(posedge clk); #1;
        fif.imem_ack   = 1'b0;
    endtask

    task automatic retirePhase(input int readyDelay, input bit br, input bit mpb, input bit mbj, input bit z);
        bit ok;
        waitValid(ok);
        if (!ok) return;
        repeat (readyDelay) begin
            fif.instr_ready = 1'b0;
            fif.imem_ack    = 1'($urandom);
            fif.imem_rdata  = $urandom;
            randomControls();
            @(posedge clk); #1;
        end
        fif.instr_ready     = 1'b1;
        fif.imem_ack        = 1'($urandom);
        fif.imem_rdata      = $urandom;
        fif.branch          = br;
        fif.mux_pc_branch   = mpb;
        fif.mux_branch_jump = mbj;
        fif.zero            = z;
        @(posedge clk); #1;
        fif.instr_ready = 1'b0;
        fif.imem_ack    = 1'b0;
        randomControls();
    endtask

    // One complete fetch/retire transaction; the expectation is queued before driving.
    task automatic applyStimulus(input logic [31:0] instr, input int ackDelay, input int readyDelay,
                                 input bit br, input bit mpb, input bit mbj, input bit z);
        txn_t t;
        t.addr          = mPc;
        t.instr         = instr;
        t.retiredBefore = mRetired;
        expQ.push_back(t);
        monEn    = 1'b1;
        mPc      = modelNextPc(mPc, instr, br, mpb, mbj, z);
        mRetired = mRetired + 32'd1;
        fetchPhase(instr, ackDelay);
        retirePhase(readyDelay, br, mpb, mbj, z);
    endtask

    task automatic doReset(input bit ackAtReset, input bit readyAtReset);
        monEn           = 1'b0;
        nrst            = 1'b0;
        fif.imem_ack    = ackAtReset;
        fif.instr_ready = readyAtReset;
        fif.imem_rdata  = $urandom;
        @(posedge clk); #1;
        fif.imem_ack    = 1'b0;
        fif.instr_ready = 1'b0;
        checkOutput("reset_imem_req", {31'b0, fif.imem_req}, 32'd0);
        checkOutput("reset_instr_valid", {31'b0, fif.instr_valid}, 32'd0);
        checkOutput("reset_opcode", {26'b0, fif.opcode}, 32'd0);
        checkOutput("reset_instr", fif.instr, 32'd0);
        checkOutput("reset_retired", fif.retired, 32'd0);
        checkOutput("reset_pc", fif.pc, RST_PC);
        nrst = 1'b1;
        expQ.delete();
        mPc      = RST_PC;
        mRetired = 32'd0;
        @(posedge clk); #1;
        checkOutput("first_req", {31'b0, fif.imem_req}, 32'd1);
        checkOutput("first_addr", fif.imem_addr, RST_PC);
    endtask

    // Monitor: compares the DUT against the head of the expectation queue every cycle.
    always @(negedge clk) begin
        txn_t e;
        if (monEn && nrst === 1'b1) begin
            if (expQ.size() == 0) begin
                if (fif.imem_req || fif.instr_valid) reportFail("unexpected_activity");
            end else begin
                e = expQ[0];
                if (fif.imem_req) begin
                    checkOutput("fetch_addr", fif.imem_addr, e.addr);
                    checkOutput("fetch_valid_low", {31'b0, fif.instr_valid}, 32'd0);
                end else if (fif.instr_valid) begin
                    checkOutput("hold_instr", fif.instr, e.instr);
                    checkOutput("hold_pc", fif.pc, e.addr);
                    checkOutput("hold_pc_plus4", fif.pc_plus4, e.addr + 32'd4);
                    checkOutput("hold_opcode", {26'b0, fif.opcode}, {26'b0, e.instr[31:26]});
                    checkOutput("hold_retired", fif.retired, e.retiredBefore);
                    if (fif.instr_ready) void'(expQ.pop_front());
                end else begin
                    reportFail("no_fetch_or_hold");
                end
            end
        end
    end

    // Overall time bound so a stuck DUT still ends the run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog_expired errors=%0d checks=%0d", errorCount, checkCount);
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: directed scenarios first, then randomized transactions.
    initial begin
        logic [31:0] rb;
        logic [5:0]  op;
        logic [31:0] rInstr;
        txn_t        t;
        nrst                = 1'b0;
        fif.imem_ack        = 1'b0;
        fif.imem_rdata      = 32'd0;
        fif.instr_ready     = 1'b0;
        fif.branch          = 1'b0;
        fif.mux_pc_branch   = 1'b0;
        fif.mux_branch_jump = 1'b1;
        fif.zero            = 1'b0;
        doReset(1'b0, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("three_retired", fif.retired, 32'd3);
        checkOutput("seq_next_addr", fif.imem_addr, 32'h0000_000C);

        applyStimulus({OP_J, 26'h40}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("jump_0x100", fif.imem_addr, 32'h0000_0100);
        applyStimulus({OP_BEQ, 10'h0, 16'hFFFF}, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("beq_taken", fif.imem_addr, 32'h0000_0100);
        applyStimulus({OP_BEQ, 10'h0, 16'hFFFF}, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("beq_not_taken", fif.imem_addr, 32'h0000_0104);
        applyStimulus({OP_J, 26'h80}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("jump_0x200", fif.imem_addr, 32'h0000_0200);
        applyStimulus({OP_BNE, 10'h0, 16'h0004}, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("bne_taken", fif.imem_addr, 32'h0000_0214);
        applyStimulus({OP_J, 26'h80}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus({OP_BNE, 10'h0, 16'h0004}, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("bne_not_taken", fif.imem_addr, 32'h0000_0204);

        rb = mRetired;
        applyStimulus(32'h0123_4567, 5, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_retired_once", fif.retired, rb + 32'd1);

        doReset(1'b1, 1'b0);

        applyStimulus({OP_BEQ, 10'h0, 16'hFFFE}, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("wrap_pc", fif.imem_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_plus4", fif.pc_plus4, 32'h0000_0000);
        applyStimulus(32'h0, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wrap_next", fif.imem_addr, 32'h0000_0000);

        t.addr          = mPc;
        t.instr         = 32'hDEAD_BEEF;
        t.retiredBefore = mRetired;
        expQ.push_back(t);
        monEn = 1'b1;
        fetchPhase(32'hDEAD_BEEF, 0);
        doReset(1'b0, 1'b1);

        for (int i = 0; i < 8192; i++) applyStimulus({OP_BEQ, 10'h0, 16'h7FFF}, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("climb_to_0x4000_0000", fif.imem_addr, 32'h4000_0000);
        applyStimulus({OP_J, 26'h0000010}, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("jump_beats_branch", fif.imem_addr, 32'h4000_0040);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_BEQ;
                1:       op = OP_BNE;
                2:       op = OP_J;
                default: op = 6'($urandom);
            endcase
            rInstr = {op, 26'($urandom)};
            applyStimulus(rInstr, $urandom_range(0, 3), $urandom_range(0, 3),
                          1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        monEn = 1'b0;
        checkOutput("final_retired", fif.retired, mRetired);
        checkOutput("final_next_addr", fif.imem_addr, mPc);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
